uart_tx_arbiter: RTL

- Shares the single UART transmitter of the DE0-Nano UART design between two byte-stream requesters: requester 0 is the command-echo path, requester 1 is the command-response/status path.
- Uses round-robin packet-level arbitration: a grant is held until the requester's last byte has been sent.
- Gates each new byte on peer flow control (uart_rts) and on transmitter idle.
- Sits between the command layer and the UART TX serializer, which runs at 115200 baud on the 50 MHz clock.

---
 rtl/uart_tx_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : uart_tx_arbiter                                                |
// | Purpose : Shares one UART TX serializer between two byte-stream          |
// |           requesters (0 = command echo, 1 = command response/status).   |
// |           Round-robin arbitration at packet granularity: a grant is held |
// |           until the owner's last byte has left the serializer, or until  |
// |           the owner stalls mid-packet for TIMEOUT_CYC cycles.            |
// |           Each byte is gated on peer flow control and serializer idle.   |
// | Ports   : clk, rst_n           - clock, async active-low reset           |
// |           req_valid/data/last  - per-requester byte stream (2 lanes)     |
// |           req_ready            - per-requester accept (owner only)       |
// |           grant                - one-hot current owner, 0 when idle      |
// |           uart_rts             - peer ready-to-receive (unsynchronised)  |
// |           tx_data, tx_start    - byte + one-cycle start to serializer    |
// |           tx_busy              - serializer busy, start..stop bit        |
// |           err_timeout          - pulse when a stalled grant is revoked   |
// |           tx_count             - bytes issued, wraps at 16 bits          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module uart_tx_arbiter #(
  parameter int TIMEOUT_CYC    = 500000,
  parameter bit RTS_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req_data,
  input  logic [1:0]  req_last,
  output logic [1:0]  req_ready,
  output logic [1:0]  grant,
  input  logic        uart_rts,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        err_timeout,
  output logic [15:0] tx_count
);

  // Stall counter only needs to reach TIMEOUT_CYC-1.
  localparam int                 c_cnt_w   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [c_cnt_w-1:0] c_to_max  = c_cnt_w'(TIMEOUT_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOCKED    = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t             r_state;
  logic [1:0]         r_grant;
  logic               r_owner;       // index of the current owner
  logic               r_last_owner;  // owner of the previous packet
  logic               r_last_flag;   // byte in flight closes the packet
  logic [7:0]         r_tx_data;
  logic               r_tx_start;
  logic               r_err_timeout;
  logic [15:0]        r_tx_count;
  logic [c_cnt_w-1:0] r_to_cnt;
  logic               r_rts_meta;
  logic               r_rts_sync;

  logic       w_rts_ok;
  logic       w_own_valid;
  logic       w_own_last;
  logic [7:0] w_own_data;
  logic       w_xfer;
  logic       w_pick;

  assign w_rts_ok    = (r_rts_sync == ~RTS_ACTIVE_LOW);
  assign w_own_valid = req_valid[r_owner];
  assign w_own_last  = req_last[r_owner];
  assign w_own_data  = r_owner ? req_data[15:8] : req_data[7:0];

  // With both requesting, the one that did not own the previous packet wins;
  // otherwise whichever is valid (req_valid[1] doubles as its index).
  assign w_pick = (&req_valid) ? ~r_last_owner : req_valid[1];

  // Combinational accept so a byte moves in the same cycle the serializer
  // and the peer are both ready; the non-owner lane stays at 0.
  always_comb begin
    req_ready = 2'b00;
    if (r_state == S_LOCKED) begin
      req_ready[r_owner] = w_own_valid & ~tx_busy & w_rts_ok;
    end
  end

  assign w_xfer = |req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_grant       <= 2'b00;
      r_owner       <= 1'b0;
      r_last_owner  <= 1'b1;   // requester 0 wins the first arbitration
      r_last_flag   <= 1'b0;
      r_tx_data     <= 8'h00;
      r_tx_start    <= 1'b0;
      r_err_timeout <= 1'b0;
      r_tx_count    <= 16'h0000;
      r_to_cnt      <= '0;
      // Power up as "peer not ready" until the synchroniser has real data.
      r_rts_meta    <= RTS_ACTIVE_LOW;
      r_rts_sync    <= RTS_ACTIVE_LOW;
    end else begin
      r_rts_meta    <= uart_rts;
      r_rts_sync    <= r_rts_meta;
      r_tx_start    <= 1'b0;
      r_err_timeout <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (|req_valid) begin
            r_owner  <= w_pick;
            r_grant  <= w_pick ? 2'b10 : 2'b01;
            r_to_cnt <= '0;
            r_state  <= S_LOCKED;
          end
        end

        S_LOCKED: begin
          if (w_xfer) begin
            r_tx_data   <= w_own_data;
            r_tx_start  <= 1'b1;
            r_tx_count  <= r_tx_count + 16'd1;
            r_last_flag <= w_own_last;
            r_to_cnt    <= '0;
            r_state     <= S_WAIT_BUSY;
          end else if (!w_own_valid) begin
            // Only an absent requester ages; one held off by rts or a busy
            // serializer keeps its count frozen.
            if (r_to_cnt == c_to_max) begin
              r_err_timeout <= 1'b1;
              r_grant       <= 2'b00;
              r_last_owner  <= r_owner;
              r_to_cnt      <= '0;
              r_state       <= S_IDLE;
            end else begin
              r_to_cnt <= r_to_cnt + c_cnt_one;
            end
          end
        end

        // The serializer raises busy within one cycle of tx_start; waiting
        // for it keeps the next byte from slipping in before busy is seen.
        S_WAIT_BUSY: begin
          if (tx_busy) begin
            r_state <= S_WAIT_DONE;
          end
        end

        S_WAIT_DONE: begin
          if (!tx_busy) begin
            r_to_cnt <= '0;
            if (r_last_flag) begin
              r_last_owner <= r_owner;
              r_grant      <= 2'b00;
              r_state      <= S_IDLE;
            end else begin
              r_state <= S_LOCKED;
            end
          end
        end

        default: begin
          r_grant <= 2'b00;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign grant       = r_grant;
  assign tx_data     = r_tx_data;
  assign tx_start    = r_tx_start;
  assign err_timeout = r_err_timeout;
  assign tx_count    = r_tx_count;

endmodule
`default_nettype wire
